// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive path:
//   - parity mode encodings used by the PARITY parameter
//   - FSM state type and state constants
//   - 3-sample majority helper used by the bit voter
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Show-ahead synchronous FIFO holding received frames.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, wr_data    write request and entry
//   rd_en             consumer ready; pops only when the FIFO is non-empty
//   rd_data           head entry (forced to 0 while empty)
//   valid             FIFO non-empty
//   count             occupancy, 0..DEPTH
//   overrun           write dropped because FIFO full and no pop this cycle
// Handshake: an entry transfers on a rising edge where valid and rd_en are
// both high; rd_en while valid is low is ignored. rd_data is stable while
// valid is high and rd_en is low.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, pop, push;

  assign full    = (count_q == FULL_CNT);
  assign pop     = rd_en & (count_q != '0);
  // A pop in the same cycle frees a slot, so a write into a full FIFO is
  // still accepted then.
  assign push    = wr_en & (~full | pop);
  assign overrun = wr_en & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid   = (count_q != '0);
  assign count   = count_q;
  // Memory is not reset; gating keeps the head outputs at 0 while empty.
  assign rd_data = valid ? mem[rd_ptr_q] : '0;

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core
// UART receiver: 2-flop input synchronizer, per-bit baud counter,
// 3-sample majority voter, frame FSM and a show-ahead receive FIFO.
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   uart_rxd            serial line, idle high, LSB first
//   rx_data/perr/ferr   head entry of the receive FIFO
//   rx_valid, rx_ready  head handshake (pop when both high)
//   fifo_count          FIFO occupancy
//   overrun             1-cycle pulse: frame dropped, FIFO full
//   break_det           1-cycle pulse: break condition detected
//   fsm_state           current FSM state (debug observation)
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          uart_rxd,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          break_det,
  output uart_state_t                   fsm_state
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW      = $clog2(BPS_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(BPS_CNT - 1);
  localparam logic [CW-1:0] CNT_LO   = CW'(BPS_CNT / 2 - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(BPS_CNT / 2);
  localparam logic [CW-1:0] CNT_HI   = CW'(BPS_CNT / 2 + 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == PAR_ODD);

  if (BPS_CNT < 8 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < PAR_NONE || PARITY > PAR_EVEN ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_rx_core: illegal parameter combination");
  end

  // Synchronizer and edge-history flops reset to 1 (idle line level).
  logic sync1_q, sync2_q, prev_q;
  logic rxd_s, fall;

  uart_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 zero_q, zero_d;          // every bit so far sampled 0
  logic                 brk_wait_q, brk_wait_d;  // holding in STOP after break
  logic                 wr_q, wr_d, brk_q, brk_d;
  logic                 vote;

  assign rxd_s = sync2_q;
  assign fall  = prev_q & ~sync2_q;
  assign vote  = maj3(s0_q, s1_q, rxd_s);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    zero_d     = zero_q;
    brk_wait_d = brk_wait_q;
    wr_d       = 1'b0;
    brk_d      = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == CNT_LO)  s0_d = rxd_s;
      if (cnt_q == CNT_MID) s1_d = rxd_s;
    end

    // Decisions are taken at CNT_HI, when the third sample is on rxd_s.
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          cnt_d   = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          zero_d  = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HI && vote) begin
          state_d = ST_IDLE;          // glitch: start bit did not hold low
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_HI) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (vote) zero_d = 1'b0;
        end
        if (cnt_q == CNT_LAST) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_q == CNT_HI) begin
          perr_d = vote ^ (^shift_q) ^ ODD_PAR;
          if (vote) zero_d = 1'b0;
        end
        if (cnt_q == CNT_LAST) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (brk_wait_q) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d    = ST_IDLE;
            brk_wait_d = 1'b0;
            bit_d      = '0;
          end
        end else if (cnt_q == CNT_HI) begin
          ferr_d = ferr_q | ~vote;
          if (bit_q == STOP_LAST) begin
            if (zero_q && !vote) begin
              brk_d      = 1'b1;
              brk_wait_d = 1'b1;
            end else begin
              // Leave at mid stop bit so a following start edge is caught.
              wr_d    = 1'b1;
              state_d = ST_IDLE;
              cnt_d   = '0;
              bit_d   = '0;
            end
          end else if (vote) begin
            zero_d = 1'b0;
          end
        end else if (cnt_q == CNT_LAST) begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      brk_wait_q <= 1'b0;
      wr_q       <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      sync1_q    <= uart_rxd;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      zero_q     <= zero_d;
      brk_wait_q <= brk_wait_d;
      wr_q       <= wr_d;
      brk_q      <= brk_d;
    end
  end

  logic [DATA_BITS+1:0] fifo_rd;

  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .wr_en   (wr_q),
    .wr_data ({ferr_q, perr_q, shift_q}),
    .rd_en   (rx_ready),
    .rd_data (fifo_rd),
    .valid   (rx_valid),
    .count   (fifo_count),
    .overrun (overrun)
  );

  assign {rx_ferr, rx_perr, rx_data} = fifo_rd;
  assign break_det = brk_q;
  assign fsm_state = state_q;

endmodule
